// File: rtl/data_memory_block14b_pkg.sv
// Shared sizes and types for the stack-machine data memory.
// Imported by the interface, the raw RAM and the top level.
package dmem_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 14;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] dmem_word_t;
  typedef logic [ADDR_WIDTH-1:0] dmem_addr_t;
endpackage

// File: rtl/data_memory_block14b_if.sv
// Bus between the stack-pointer/address logic (master) and the data memory (slave).
// The full 16-bit address is carried; the memory decodes only the low bits.
interface data_memory_block14b_if;
  import dmem_pkg::*;

  logic [15:0] addr;
  dmem_word_t  din;
  logic        wea;
  dmem_word_t  douta;
  dmem_word_t  doutb;

  modport master (output addr, output din, output wea, input douta, input doutb);
  modport slave  (input addr, input din, input wea, output douta, output doutb);
endinterface

// File: rtl/data_memory_block14b_dmem_ram_1w2r.sv
// Raw word array: one write port, two registered read ports, read-first on collision.
// Kept free of resets so synthesis maps it onto block RAM.
module dmem_ram_1w2r
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  dmem_addr_t waddr_i,
  input  dmem_word_t wdata_i,
  input  dmem_addr_t raddr_a_i,
  input  dmem_addr_t raddr_b_i,
  output dmem_word_t rdata_a_o,
  output dmem_word_t rdata_b_o
);
  // Contents come up as zeros from the configuration image.
  dmem_word_t mem_q [DEPTH] = '{default: '0};
  dmem_word_t rdata_a_q;
  dmem_word_t rdata_b_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;
endmodule

// File: rtl/data_memory_block14b.sv
// Stack data memory: port A reads addr (top of stack), port B reads addr-1 (next on stack).
// Define DATAMEM_WRITE_FIRST_EN for write-first port A; otherwise port A is read-first.
module data_memory_block14b
  import dmem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_block14b_if.slave  bus
);
  dmem_addr_t addr_a;
  dmem_addr_t addr_b;
  dmem_word_t ram_a;
  dmem_word_t ram_b;
  logic [1:0] rst_sync_q;
  logic       run;
  logic       we;
  logic       out_vld_q;
  logic       unused_addr_hi;

  // Upper address bits alias onto the decoded range; decrement wraps 0 -> DEPTH-1.
  assign addr_a         = bus.addr[ADDR_WIDTH-1:0];
  assign addr_b         = addr_a - dmem_addr_t'(1);
  assign unused_addr_hi = ^bus.addr[15:ADDR_WIDTH];

  // Reset asserts immediately but releases only after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];
  assign we  = bus.wea & run;

  dmem_ram_1w2r u_ram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (addr_a),
    .wdata_i   (bus.din),
    .raddr_a_i (addr_a),
    .raddr_b_i (addr_b),
    .rdata_a_o (ram_a),
    .rdata_b_o (ram_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= run;
    end
  end

`ifdef DATAMEM_WRITE_FIRST_EN
  logic       byp_q;
  dmem_word_t din_q;

  // A write edge forwards the written word to port A instead of the stale array read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
      din_q <= '0;
    end else begin
      byp_q <= we;
      din_q <= bus.din;
    end
  end

  assign bus.douta = !out_vld_q ? '0 : (byp_q ? din_q : ram_a);
`else
  assign bus.douta = out_vld_q ? ram_a : '0;
`endif

  assign bus.doutb = out_vld_q ? ram_b : '0;
endmodule

// File: tb/tb_data_memory_block14b.sv
// Randomized check of the stack data memory against an array model of its read/write rules.
// Honors DATAMEM_WRITE_FIRST_EN for the expected port A collision behaviour.
module tb_data_memory_block14b;
  logic clk;
  logic rst_n;

`ifdef DATAMEM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  data_memory_block14b_if dmem_bus ();

  data_memory_block14b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ref_mem [16384];
  int          n_checks;
  int          n_fail;
  logic [15:0] got_a;
  logic [15:0] got_b;
  int          txn;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One access: drive at the falling edge, check outputs just after the rising edge.
  task automatic do_cycle(input logic [15:0] addr, input logic [15:0] din, input logic we);
    int          a;
    int          b;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    @(negedge clk);
    dmem_bus.addr = addr;
    dmem_bus.din  = din;
    dmem_bus.wea  = we;
    a     = int'(addr) % 16384;
    b     = (a + 16383) % 16384;
    exp_b = ref_mem[b];
    exp_a = (WRITE_FIRST && we) ? din : ref_mem[a];
    @(posedge clk);
    #1;
    got_a = dmem_bus.douta;
    got_b = dmem_bus.doutb;
    check_val("douta", got_a, exp_a);
    check_val("doutb", got_b, exp_b);
    if (we) ref_mem[a] = din;
    txn++;
    $display("txn %0d addr=0x%04h din=0x%04h we=%0b douta=0x%04h doutb=0x%04h",
             txn, addr, din, we, got_a, got_b);
  endtask

  initial begin
    int          sel;
    logic [15:0] addr;
    logic [15:0] last_addr;

    n_checks = 0;
    n_fail   = 0;
    txn      = 0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;

    rst_n         = 1'b0;
    dmem_bus.addr = '0;
    dmem_bus.din  = '0;
    dmem_bus.wea  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_douta", dmem_bus.douta, 16'h0000);
    check_val("rst_doutb", dmem_bus.doutb, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Directed sequence
    do_cycle(16'd0, 16'd0, 1'b0);
    check_val("tp_first_a", got_a, 16'd0);
    check_val("tp_first_b", got_b, 16'd0);
    do_cycle(16'd1, 16'd100, 1'b1);
    check_val("tp_wr1_a", got_a, WRITE_FIRST ? 16'd100 : 16'd0);
    do_cycle(16'd1, 16'd0, 1'b0);
    check_val("tp_wr1_next", got_a, 16'd100);
    do_cycle(16'd2, 16'd1000, 1'b0);
    check_val("tp_nowr_a", got_a, 16'd0);
    check_val("tp_nowr_b", got_b, 16'd100);
    do_cycle(16'd2, 16'd10000, 1'b1);
    check_val("tp_hold1_a", got_a, WRITE_FIRST ? 16'd10000 : 16'd0);
    check_val("tp_hold1_b", got_b, 16'd100);
    do_cycle(16'd2, 16'd10000, 1'b1);
    check_val("tp_hold2_a", got_a, 16'd10000);
    check_val("tp_hold2_b", got_b, 16'd100);

    do_cycle(16'h3FFF, 16'h1234, 1'b1);
    do_cycle(16'hFFFF, 16'h0000, 1'b0);
    check_val("alias_a", got_a, 16'h1234);
    do_cycle(16'h0000, 16'h0000, 1'b0);
    check_val("wrap_b", got_b, 16'h1234);

    // Reset asserted in the middle of a write to word 5
    do_cycle(16'd5, 16'h0555, 1'b1);
    do_cycle(16'd1, 16'h0000, 1'b0);
    @(negedge clk);
    dmem_bus.addr = 16'd5;
    dmem_bus.din  = 16'hBEEF;
    dmem_bus.wea  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_a", dmem_bus.douta, 16'h0000);
    check_val("rst_async_b", dmem_bus.doutb, 16'h0000);
    @(posedge clk);
    #1;
    check_val("rst_hold_a", dmem_bus.douta, 16'h0000);
    check_val("rst_hold_b", dmem_bus.doutb, 16'h0000);
    @(negedge clk);
    dmem_bus.wea = 1'b0;
    rst_n        = 1'b1;
    repeat (4) @(posedge clk);
    do_cycle(16'd5, 16'h0000, 1'b0);
    check_val("rst_drop_a", got_a, 16'h0555);
    do_cycle(16'd2, 16'h0000, 1'b0);
    check_val("rst_keep_b", got_b, 16'd100);

    // Random traffic concentrated on collisions and the wrap boundary
    last_addr = 16'd0;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = 16'($urandom);
        1:       addr = {2'($urandom_range(0, 3)), 14'($urandom_range(0, 7))};
        2:       addr = {2'($urandom_range(0, 3)), 14'(16376 + $urandom_range(0, 7))};
        default: addr = last_addr;
      endcase
      do_cycle(addr, 16'($urandom), 1'($urandom_range(0, 1)));
      last_addr = addr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
